// File: rtl/beam_sum_rx_pkg.sv
// beam_sum_rx_pkg: shared PUSCH defaults and the packed {re, im} output sample type.
package beam_sum_rx_pkg;
    localparam int MAC_LAT_D = 10;
    localparam int IW_D      = 48;
    localparam int OW_D      = 16;
    localparam int SHIFT_D   = 15;
    localparam int BEAMS_D   = 16;

    typedef struct packed {
        logic signed [OW_D-1:0] re;
        logic signed [OW_D-1:0] im;
    } sample_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: show-ahead synchronous FIFO; head word is visible on o_rdata whenever not empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr, w_rd;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_count = r_count;
    assign w_rd    = i_rd && !o_empty;
    // a full FIFO still takes a write when the head leaves in the same cycle
    assign w_wr    = i_wr && (!o_full || w_rd);
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge i_clk)
        if (w_wr) r_mem[r_wptr] <= i_wdata;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
endmodule

// File: rtl/beam_sum_rx.sv
// beam_sum_rx: realigns valid/sop with the MAC array output, rounds and saturates
// each beam sum, tags it with its beam index and queues it for downstream.
module beam_sum_rx
    import beam_sum_rx_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_D,
    parameter int IW      = IW_D,
    parameter int OW      = OW_D,
    parameter int SHIFT   = SHIFT_D,
    parameter int BEAMS   = BEAMS_D,
    parameter int DEPTH   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_rvalid,
    input  logic                      i_sop,
    input  logic [2*IW-1:0]           i_sum_data,
    output logic [2*OW-1:0]           o_data,
    output logic [$clog2(BEAMS)-1:0]  o_beam_idx,
    output logic                      o_last,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_overflow,
    output logic [15:0]               o_sat_cnt
);
    localparam int BW = $clog2(BEAMS);
    localparam int FW = 2*OW + BW + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic signed [IW:0] RND  = (IW+1)'(1) << (SHIFT-1);
    localparam logic signed [IW:0] MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW:0] MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    // returns {clipped, value}
    function automatic logic [OW:0] rnd_sat(input logic [IW-1:0] x);
        logic signed [IW:0] t;
        t = ($signed({x[IW-1], x}) + RND) >>> SHIFT;
        return t > MAXV ? {2'b10, {(OW-1){1'b1}}} :
               t < MINV ? {2'b11, {(OW-1){1'b0}}} : {1'b0, t[OW-1:0]};
    endfunction

    logic [MAC_LAT-1:0] r_vld_dly, r_sop_dly;
    logic               r_pvld, r_plast, r_overflow;
    logic [2*OW-1:0]    r_pdata;
    logic [BW-1:0]      r_pidx, r_beam, w_idx;
    logic [15:0]        r_sat_cnt;
    logic [OW:0]        w_re, w_im;
    logic [1:0]         w_clips;
    logic [16:0]        w_sat_sum;
    logic               w_vld, w_sop, w_pop, w_full, w_empty;
    logic [FW-1:0]      w_rdata;
    logic [CW-1:0]      w_count;

    assign w_vld = r_vld_dly[MAC_LAT-1];
    assign w_sop = r_sop_dly[MAC_LAT-1];

    always_comb begin
        w_re      = rnd_sat(i_sum_data[2*IW-1:IW]);
        w_im      = rnd_sat(i_sum_data[IW-1:0]);
        w_clips   = {1'b0, w_re[OW]} + {1'b0, w_im[OW]};
        w_sat_sum = {1'b0, r_sat_cnt} + {15'b0, w_clips};
        w_idx     = w_sop ? '0 : r_beam;
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            r_vld_dly  <= '0;
            r_sop_dly  <= '0;
            r_pvld     <= 1'b0;
            r_pdata    <= '0;
            r_pidx     <= '0;
            r_plast    <= 1'b0;
            r_beam     <= '0;
            r_sat_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_vld_dly <= (r_vld_dly << 1) | MAC_LAT'(i_rvalid);
            r_sop_dly <= (r_sop_dly << 1) | MAC_LAT'(i_rvalid && i_sop);
            r_pvld    <= w_vld;
            if (w_vld) begin
                r_pdata   <= {w_re[OW-1:0], w_im[OW-1:0]};
                r_pidx    <= w_idx;
                r_plast   <= w_idx == BW'(BEAMS-1);
                r_beam    <= w_idx == BW'(BEAMS-1) ? '0 : w_idx + BW'(1);
                r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
            end
            // the beam counter has already moved on, so a dropped sample leaves a gap in indices
            if (r_pvld && w_full && !w_pop) r_overflow <= 1'b1;
        end

    assign w_pop = !w_empty && i_ready;

    sync_fifo_fwft #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (r_pvld),
        .i_wdata ({r_pdata, r_pidx, r_plast}),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign o_valid    = !w_empty;
    assign {o_data, o_beam_idx, o_last} = w_rdata;
    assign o_overflow = r_overflow;
    assign o_sat_cnt  = r_sat_cnt;

    a_full_count: assert property (@(posedge i_clk) disable iff (i_reset)
        w_full == (w_count == CW'(DEPTH)));
endmodule

// File: doc/beam_sum_rx.md
BEAM_SUM_RX -- requirements
Module: beam_sum_rx

Interface
REQ-001 SHALL have parameter MAC_LAT, default 10: cycles from i_rvalid to the matching i_sum_data at the MAC array.
REQ-002 SHALL have parameter IW, default 48: width of each real and imaginary input component.
REQ-003 SHALL have parameter OW, default 16: width of each real and imaginary output component.
REQ-004 SHALL have parameter SHIFT, default 15: arithmetic right-shift applied before rounding.
REQ-005 SHALL have parameter BEAMS, default 16: number of beams per symbol.
REQ-006 SHALL have parameter DEPTH, default 16 (power of 2): output FIFO depth.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port i_rvalid, input, 1 bit: valid presented alongside the MAC array inputs.
REQ-010 SHALL have port i_sop, input, 1 bit: start of symbol, qualified by i_rvalid, same cycle as i_rvalid.
REQ-011 SHALL have port i_sum_data, input, 2*IW bits: {re, im} signed beam sum from the MAC array, carrying no valid of its own.
REQ-012 SHALL have port o_data, output, 2*OW bits: {re, im} rounded and saturated sample.
REQ-013 SHALL have port o_beam_idx, output, $clog2(BEAMS) bits: beam index of o_data.
REQ-014 SHALL have port o_last, output, 1 bit: marks beam BEAMS-1.
REQ-015 SHALL have port o_valid, output, 1 bit: FIFO holds data.
REQ-016 SHALL have port i_ready, input, 1 bit: downstream accept.
REQ-017 SHALL have port o_overflow, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-018 SHALL have port o_sat_cnt, output, 16 bits: saturating count of clipped components.

Function
REQ-019 SHALL delay i_rvalid and i_sop through a MAC_LAT-stage shift register so that the delayed valid is aligned with i_sum_data.
REQ-020 SHALL, in each aligned-valid cycle, process re and im independently: add 2^(SHIFT-1), arithmetic-shift right by SHIFT, then saturate to signed OW bits.
REQ-021 SHALL saturate positive overflow to 2^(OW-1)-1 and negative overflow to -2^(OW-1).
REQ-022 SHALL register the rounding and saturation result in one pipeline stage, giving MAC_LAT+1 cycles from i_rvalid to the FIFO write.
REQ-023 SHALL increment o_sat_cnt by the number of components clipped in a sample (0, 1 or 2), holding the count at 0xFFFF.
REQ-024 SHALL maintain the beam counter as follows: a delayed sop forces the index to 0 for that sample; otherwise the index increments per written sample and wraps BEAMS-1 -> 0.
REQ-025 SHALL set last = (index == BEAMS-1).
REQ-026 SHALL write {data, beam_idx, last} into the FIFO.
REQ-027 SHALL assert o_valid exactly when the FIFO is not empty.
REQ-028 SHALL pop the FIFO when o_valid and i_ready are both high.
REQ-029 SHALL hold o_data, o_beam_idx and o_last stable while o_valid is high and i_ready is low.
REQ-030 SHALL accept a write when the FIFO is full only if a pop occurs in the same cycle.
REQ-031 SHALL otherwise drop the sample, set o_overflow, and still advance the beam counter.
REQ-032 SHALL, on a simultaneous write and pop when empty, let the written sample appear on o_valid in the next cycle; there SHALL be no fall-through.
REQ-033 SHALL leave o_valid low on a pop with no write when the FIFO held 1 entry.

Reset
REQ-034 SHALL, on i_reset assertion, asynchronously clear the valid and sop delay lines, FIFO pointers and count, beam counter, o_overflow and o_sat_cnt.
REQ-035 SHALL drive o_valid = 0 and o_data, o_beam_idx and o_last = 0 while in reset.
REQ-036 SHALL discard any samples in flight when reset is asserted mid-stream; none SHALL emerge after release.
REQ-037 SHALL not reset the FIFO storage RAM.
REQ-038 SHALL write no sample until MAC_LAT+1 cycles after the first i_rvalid following reset release.

Structure
REQ-039 SHALL place the MAC_LAT, IW, OW, SHIFT and BEAMS defaults in the shared PUSCH package, together with the packed {re, im} sample typedef.
REQ-040 SHALL implement the FIFO as one sub-module, sync_fifo_fwft, with parameters width and depth and ports for full, empty and count.
REQ-041 SHALL implement rounding, saturation and beam counting inline in beam_sum_rx.

Verification
REQ-042 SHALL check: with the defaults, i_sum_data re = 0x000000012345 (74565) and im = -74565, i_rvalid pulsed at cycle 0 -> the FIFO write occurs at cycle 11, and o_data re = 2, im = -2 (0x0002, 0xFFFE).
REQ-043 SHALL check: re = 2^40 -> re = 0x7FFF and o_sat_cnt increments by 1; re and im both = -2^40 -> 0x8000 each and o_sat_cnt increments by 2.
REQ-044 SHALL check: 20 consecutive valids with sop on the first -> o_beam_idx sequence 0..15 then 0..3, with o_last on the 16th sample only.
REQ-045 SHALL check: i_ready held low and 17 samples sent -> first 16 retained in order, 17th dropped, o_overflow = 1, and the beam index of the next accepted sample = 1 (counter advanced past the drop).
REQ-046 SHALL check: FIFO full with i_ready high and a write in the same cycle -> no overflow and the count stays 16.
REQ-047 SHALL check: i_reset asserted while 5 samples are in the pipeline and 3 in the FIFO -> o_valid drops immediately and no output appears after release without new i_rvalid.
